// File: rtl/prefetch_pkg.sv
// Shared definitions for the instruction prefetch queue: halfword width,
// compressed-instruction detection and pointer width helpers.
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package prefetch_pkg;

    localparam int HALF_WIDTH = 16;

    // Length tag of a full 32-bit instruction in the low two bits of its first halfword
    localparam logic [HALF_WIDTH-1:0] FULL_LEN_MASK = 16'h0003;

    // A halfword starts a compressed instruction unless its low two bits are both set
    function automatic logic is_compressed(input logic [HALF_WIDTH-1:0] half);
        logic [HALF_WIDTH-1:0] tag_s;
        tag_s = half & FULL_LEN_MASK;
        return (tag_s != FULL_LEN_MASK);
    endfunction

    // Word write pointer width: ring index bits plus one wrap bit
    function automatic int ptr_w(input int depth_words);
        return $clog2(depth_words) + 1;
    endfunction

    // Halfword read pointer width: ring index bits plus one wrap bit
    function automatic int rd_ptr_w(input int depth_words);
        return $clog2(2 * depth_words) + 1;
    endfunction

endpackage

// File: rtl/prefetch_fifo_ring.sv
// Halfword ring storage: one whole-word write port, two combinational
// halfword read ports. Indices wrap naturally through their width.
module halfword_ring
    import prefetch_pkg::*;
#(
    parameter int DEPTH_HALVES = 8,
    localparam int IDX_W = $clog2(DEPTH_HALVES)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [IDX_W-2:0]        wr_word_idx,
    input  logic [2*HALF_WIDTH-1:0] wr_word,
    input  logic [IDX_W-1:0]        rd_idx0,
    input  logic [IDX_W-1:0]        rd_idx1,
    output logic [HALF_WIDTH-1:0]   rd_half0,
    output logic [HALF_WIDTH-1:0]   rd_half1
);

    logic [HALF_WIDTH-1:0] slots_r [DEPTH_HALVES];

    // Store a fetched word: low half at the even slot, high half at the odd slot
    always_ff @(posedge clk) begin
        if (wr_en) begin
            slots_r[{wr_word_idx, 1'b0}] <= wr_word[HALF_WIDTH-1:0];
            slots_r[{wr_word_idx, 1'b1}] <= wr_word[2*HALF_WIDTH-1:HALF_WIDTH];
        end
    end

    assign rd_half0 = slots_r[rd_idx0];
    assign rd_half1 = slots_r[rd_idx1];

endmodule

// File: rtl/prefetch_fifo.sv
// Instruction prefetch queue: accepts fetch words, presents one aligned
// (32-bit or compressed) instruction per cycle to decode, supports flush
// with a halfword-aligned restart.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH_WORDS = 4,
    parameter int WORD_WIDTH  = `RISCV_WORD_WIDTH,
    localparam int CNT_W      = $clog2(2 * DEPTH_WORDS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  flush_half,
    input  logic                  wr_valid,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [31:0]           rd_instr,
    output logic                  rd_compressed,
    output logic [CNT_W-1:0]      count_half
);

    localparam int PTR_W    = ptr_w(DEPTH_WORDS);
    localparam int RD_PTR_W = rd_ptr_w(DEPTH_WORDS);
    localparam int IDX_W    = RD_PTR_W - 1;

    // Highest fill level that still leaves room for a whole word
    localparam logic [RD_PTR_W-1:0] WR_LIMIT = RD_PTR_W'(2 * DEPTH_WORDS - 2);

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [RD_PTR_W-1:0]   rd_ptr_r;
    logic                  skip_r;

    logic [PTR_W-1:0]      wr_ptr_nxt_s;
    logic [RD_PTR_W-1:0]   rd_ptr_nxt_s;
    logic                  skip_nxt_s;

    logic [RD_PTR_W-1:0]   count_s;
    logic [HALF_WIDTH-1:0] head_half_s;
    logic [HALF_WIDTH-1:0] next_half_s;
    logic                  head_c_s;
    logic                  rd_valid_s;
    logic                  wr_ready_s;
    logic                  wr_fire_s;
    logic                  rd_fire_s;
    logic [IDX_W-1:0]      head_idx_s;
    logic [IDX_W-1:0]      next_idx_s;

    halfword_ring #(
        .DEPTH_HALVES (2 * DEPTH_WORDS)
    ) u_ring (
        .clk         (clk),
        .wr_en       (wr_fire_s),
        .wr_word_idx (wr_ptr_r[PTR_W-2:0]),
        .wr_word     (wr_data),
        .rd_idx0     (head_idx_s),
        .rd_idx1     (next_idx_s),
        .rd_half0    (head_half_s),
        .rd_half1    (next_half_s)
    );

    // Occupancy and handshake status, derived only from registered state
    always_comb begin
        count_s    = {wr_ptr_r, 1'b0} - rd_ptr_r;
        head_idx_s = rd_ptr_r[IDX_W-1:0];
        next_idx_s = rd_ptr_r[IDX_W-1:0] + IDX_W'(1);
        head_c_s   = is_compressed(head_half_s);
        wr_ready_s = (count_s <= WR_LIMIT);
        if (count_s >= RD_PTR_W'(2)) begin
            rd_valid_s = 1'b1;
        end else if (count_s == RD_PTR_W'(1)) begin
            rd_valid_s = head_c_s;
        end else begin
            rd_valid_s = 1'b0;
        end
        wr_fire_s = wr_valid && wr_ready_s;
        rd_fire_s = rd_valid_s && rd_ready;
    end

    // Next pointer / skip state: flush wins, a pending skip drops the first low half
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        skip_nxt_s   = skip_r;
        if (flush) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            rd_ptr_nxt_s = {RD_PTR_W{1'b0}};
            skip_nxt_s   = flush_half;
        end else begin
            if (wr_fire_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (wr_fire_s && skip_r) begin
                rd_ptr_nxt_s = RD_PTR_W'(1);
                skip_nxt_s   = 1'b0;
            end else if (rd_fire_s) begin
                rd_ptr_nxt_s = rd_ptr_r + (head_c_s ? RD_PTR_W'(1) : RD_PTR_W'(2));
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
        end
    end

    // Pointer and skip registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {RD_PTR_W{1'b0}};
            skip_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            skip_r   <= skip_nxt_s;
        end
    end

    // Head instruction presentation, forced to zero while nothing is valid
    always_comb begin
        if (!rd_valid_s) begin
            rd_instr      = 32'h0000_0000;
            rd_compressed = 1'b0;
        end else if (head_c_s) begin
            rd_instr      = {16'h0000, head_half_s};
            rd_compressed = 1'b1;
        end else begin
            rd_instr      = {next_half_s, head_half_s};
            rd_compressed = 1'b0;
        end
    end

    assign rd_valid   = rd_valid_s;
    assign wr_ready   = wr_ready_s;
    assign count_half = count_s;

endmodule

// File: tb/tb_prefetch_fifo.sv
// Directed testbench for prefetch_fifo (DEPTH_WORDS = 4).
module tb_prefetch_fifo;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        flush_half;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_instr;
    logic        rd_compressed;
    logic [3:0]  count_half;

    int tests_run = 0;
    int tests_failed = 0;

    prefetch_fifo #(.DEPTH_WORDS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .flush_half    (flush_half),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_instr      (rd_instr),
        .rd_compressed (rd_compressed),
        .count_half    (count_half)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] stream_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'hA0, b, 16'h0013};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic do_flush(input logic half);
        flush      = 1'b1;
        flush_half = half;
        tick();
        flush      = 1'b0;
        flush_half = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; flush_half = 1'b0;
        wr_valid = 1'b0; wr_data = 32'h0; rd_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (count_half !== 4'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1 ||
            rd_instr !== 32'h0 || rd_compressed !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: cnt=%0d rv=%b wr=%b instr=%h c=%b, want 0 0 1 0 0",
                     count_half, rd_valid, wr_ready, rd_instr, rd_compressed);
        end
    endtask

    task automatic test_full_words();
        do_write(32'h0004_0113);
        tests_run++;
        if (rd_valid !== 1'b1 || count_half !== 4'd2 || rd_instr !== 32'h0004_0113) begin
            tests_failed++;
            $display("FAIL latency: rv=%b cnt=%0d instr=%h, want 1 2 00040113", rd_valid, count_half, rd_instr);
        end
        do_write(32'h00A0_0093);
        tests_run++;
        if (count_half !== 4'd4 || rd_instr !== 32'h0004_0113 || rd_compressed !== 1'b0) begin
            tests_failed++;
            $display("FAIL word_rd1: cnt=%0d instr=%h c=%b, want 4 00040113 0", count_half, rd_instr, rd_compressed);
        end
        do_read();
        tests_run++;
        if (count_half !== 4'd2 || rd_instr !== 32'h00A0_0093 || rd_compressed !== 1'b0) begin
            tests_failed++;
            $display("FAIL word_rd2: cnt=%0d instr=%h c=%b, want 2 00a00093 0", count_half, rd_instr, rd_compressed);
        end
        do_read();
        tests_run++;
        if (count_half !== 4'd0 || rd_valid !== 1'b0 || rd_instr !== 32'h0) begin
            tests_failed++;
            $display("FAIL word_empty: cnt=%0d rv=%b instr=%h, want 0 0 0", count_half, rd_valid, rd_instr);
        end
    endtask

    task automatic test_compressed();
        do_write(32'h4501_0505);
        tests_run++;
        if (rd_instr !== 32'h0000_0505 || rd_compressed !== 1'b1 || count_half !== 4'd2) begin
            tests_failed++;
            $display("FAIL rvc_rd1: instr=%h c=%b cnt=%0d, want 00000505 1 2", rd_instr, rd_compressed, count_half);
        end
        do_read();
        tests_run++;
        if (rd_instr !== 32'h0000_4501 || rd_compressed !== 1'b1 || count_half !== 4'd1 || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rvc_rd2: instr=%h c=%b cnt=%0d rv=%b, want 00004501 1 1 1",
                     rd_instr, rd_compressed, count_half, rd_valid);
        end
        do_read();
        tests_run++;
        if (count_half !== 4'd0 || rd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rvc_empty: cnt=%0d rv=%b, want 0 0", count_half, rd_valid);
        end
    endtask

    task automatic test_straddle();
        do_write(32'h0113_4505);
        do_write(32'h0000_0004);
        tests_run++;
        if (rd_instr !== 32'h0000_4505 || rd_compressed !== 1'b1) begin
            tests_failed++;
            $display("FAIL straddle_head: instr=%h c=%b, want 00004505 1", rd_instr, rd_compressed);
        end
        do_read();
        tests_run++;
        if (rd_instr !== 32'h0004_0113 || rd_compressed !== 1'b0 || count_half !== 4'd3) begin
            tests_failed++;
            $display("FAIL straddle_join: instr=%h c=%b cnt=%0d, want 00040113 0 3", rd_instr, rd_compressed, count_half);
        end
        do_read();
        tests_run++;
        if (rd_valid !== 1'b1 || rd_instr !== 32'h0 || rd_compressed !== 1'b1 || count_half !== 4'd1) begin
            tests_failed++;
            $display("FAIL straddle_tail: rv=%b instr=%h c=%b cnt=%0d, want 1 0 1 1",
                     rd_valid, rd_instr, rd_compressed, count_half);
        end
        do_flush(1'b0);
    endtask

    task automatic test_full_wrap();
        int wi;
        int ri;
        logic wf;
        logic rf;
        for (int i = 0; i < 4; i++) begin
            do_write(stream_word(i));
        end
        tests_run++;
        if (wr_ready !== 1'b0 || count_half !== 4'd8) begin
            tests_failed++;
            $display("FAIL full: wr_ready=%b cnt=%0d, want 0 8", wr_ready, count_half);
        end
        do_write(32'hDEAD_BEEF);
        tests_run++;
        if (count_half !== 4'd8 || rd_instr !== stream_word(0)) begin
            tests_failed++;
            $display("FAIL full_reject: cnt=%0d instr=%h, want 8 %h", count_half, rd_instr, stream_word(0));
        end
        do_read();
        tests_run++;
        if (wr_ready !== 1'b1 || count_half !== 4'd6 || rd_instr !== stream_word(1)) begin
            tests_failed++;
            $display("FAIL full_release: wr_ready=%b cnt=%0d instr=%h, want 1 6 %h",
                     wr_ready, count_half, rd_instr, stream_word(1));
        end
        wi = 4;
        ri = 1;
        for (int cyc = 0; cyc < 200 && ri < 16; cyc++) begin
            wr_valid = (wi < 16);
            wr_data  = stream_word(wi);
            rd_ready = 1'b1;
            wf = wr_valid && wr_ready;
            rf = rd_valid;
            if (rd_valid) begin
                tests_run++;
                if (rd_instr !== stream_word(ri)) begin
                    tests_failed++;
                    $display("FAIL wrap_order[%0d]: instr=%h, want %h", ri, rd_instr, stream_word(ri));
                end
            end
            tick();
            if (wf) wi++;
            if (rf) ri++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        tests_run++;
        if (ri != 16 || count_half !== 4'd0) begin
            tests_failed++;
            $display("FAIL wrap_done: reads=%0d cnt=%0d, want 16 0", ri, count_half);
        end
    endtask

    task automatic test_flush_half();
        for (int i = 0; i < 3; i++) begin
            do_write(stream_word(i));
        end
        do_flush(1'b1);
        tests_run++;
        if (count_half !== 4'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_empty: cnt=%0d rv=%b wr=%b, want 0 0 1", count_half, rd_valid, wr_ready);
        end
        do_write(32'h0113_FFFF);
        tests_run++;
        if (count_half !== 4'd1 || rd_valid !== 1'b0 || rd_instr !== 32'h0) begin
            tests_failed++;
            $display("FAIL skip_partial: cnt=%0d rv=%b instr=%h, want 1 0 0", count_half, rd_valid, rd_instr);
        end
        do_write(32'h0000_0004);
        tests_run++;
        if (rd_valid !== 1'b1 || rd_instr !== 32'h0004_0113 || rd_compressed !== 1'b0 || count_half !== 4'd3) begin
            tests_failed++;
            $display("FAIL skip_join: rv=%b instr=%h c=%b cnt=%0d, want 1 00040113 0 3",
                     rd_valid, rd_instr, rd_compressed, count_half);
        end
        do_flush(1'b0);
    endtask

    task automatic test_flush_collision();
        do_write(32'h00A0_0093);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'h1234_5673;
        rd_ready = 1'b1;
        tick();
        flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        tests_run++;
        if (count_half !== 4'd0 || rd_valid !== 1'b0 || rd_instr !== 32'h0 || wr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_collide: cnt=%0d rv=%b instr=%h wr=%b, want 0 0 0 1",
                     count_half, rd_valid, rd_instr, wr_ready);
        end
        do_write(32'h0004_0113);
        tests_run++;
        if (rd_instr !== 32'h0004_0113 || count_half !== 4'd2) begin
            tests_failed++;
            $display("FAIL flush_noskip: instr=%h cnt=%0d, want 00040113 2", rd_instr, count_half);
        end
    endtask

    task automatic test_async_reset();
        do_write(32'h4501_0505);
        wr_valid = 1'b1;
        wr_data  = 32'h00A0_0093;
        rd_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (count_half !== 4'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1 ||
            rd_instr !== 32'h0 || rd_compressed !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: cnt=%0d rv=%b wr=%b instr=%h c=%b, want 0 0 1 0 0",
                     count_half, rd_valid, wr_ready, rd_instr, rd_compressed);
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_compressed();
        test_straddle();
        test_full_wrap();
        test_flush_half();
        test_flush_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
